// File: rtl/gf180mcu_fd_sc_mcu7t5v0__fillsw_seq.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__fillsw_seq
//
// Staged-enable sequencer for switchable fill/decap segments. It brings NSEG
// capacitive fill segments onto the rail one at a time, STEP+1 cycles apart,
// to limit inrush current and di/dt. Segments turn on from SW[0] upwards and
// turn off in reverse order.
//
// Parameters:
//   NSEG   - number of switched segments (1..32)
//   STEP_W - width of the inter-step delay field
//   TMO    - power-good wait limit in cycles (PG feature only)
//
// Ports:
//   CLK   in   clock, rising edge
//   RST   in   synchronous active-high reset
//   EN    in   level request: 1 = all segments on, 0 = all off
//   STEP  in   inter-step delay; switch events are STEP+1 cycles apart
//   SW    out  segment enables, SW[i] = (i < lvl)
//   BUSY  out  ramp in progress (UP or DN)
//   DONE  out  all segments on (ON)
//   PG    in   per-segment power-good      (only with PG feature)
//   FAULT out  sticky power-good timeout   (only with PG feature)
//
// Optional feature macro: GF180MCU_FD_SC_MCU7T5V0__FILLSW_SEQ_PG_EN
//   When defined, each up-step waits for PG of the newest segment before its
//   delay starts counting; a wait of TMO cycles raises FAULT and forces a
//   stepped ramp-down. FAULT masks EN until RST.
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__fillsw_seq #(
   parameter int NSEG   = 8,
   parameter int STEP_W = 8,
   parameter int TMO    = 255
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   input  logic [STEP_W-1:0] STEP,
   output logic [NSEG-1:0]   SW,
   output logic              BUSY,
   output logic              DONE
`ifdef GF180MCU_FD_SC_MCU7T5V0__FILLSW_SEQ_PG_EN
   ,
   input  logic [NSEG-1:0]   PG,
   output logic              FAULT
`endif
);

   localparam int LVL_W = $clog2(NSEG + 1);
   localparam logic [LVL_W-1:0]  LVL_ZERO = '0;
   localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
   localparam logic [LVL_W-1:0]  LVL_MAX  = LVL_W'(NSEG);
   localparam logic [STEP_W-1:0] CNT_ONE  = STEP_W'(1);

   typedef enum logic [1:0] {
      S_OFF = 2'd0,
      S_UP  = 2'd1,
      S_ON  = 2'd2,
      S_DN  = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [LVL_W-1:0]  lvl, lvl_nxt;
   logic [STEP_W-1:0] cnt, cnt_nxt;
   logic              en_eff;

   // Thermometer decode of a level into segment enables.
   function automatic logic [NSEG-1:0] decode(input logic [LVL_W-1:0] l);
      logic [NSEG-1:0] r;
      r = '0;
      for (int i = 0; i < NSEG; i++) begin
         r[i] = (LVL_W'(i) < l);
      end
      return r;
   endfunction

`ifdef GF180MCU_FD_SC_MCU7T5V0__FILLSW_SEQ_PG_EN
   localparam logic [STEP_W:0] TMO_V = (STEP_W + 1)'(TMO);

   logic [STEP_W:0] wait_cnt, wait_nxt;
   logic            fault_nxt;
   logic            pg_ok;

   // Power-good of the most recently enabled segment, PG[lvl-1].
   function automatic logic pg_top(input logic [NSEG-1:0] pg, input logic [LVL_W-1:0] l);
      logic s;
      s = 1'b0;
      for (int i = 0; i < NSEG; i++) begin
         if (LVL_W'(i + 1) == l) s = pg[i];
      end
      return s;
   endfunction

   assign pg_ok  = pg_top(PG, lvl);
   // A latched fault behaves exactly like a released request.
   assign en_eff = EN & ~FAULT;
`else
   assign en_eff = EN;
`endif

   always_comb begin
      state_nxt = state;
      lvl_nxt   = lvl;
      cnt_nxt   = cnt;
`ifdef GF180MCU_FD_SC_MCU7T5V0__FILLSW_SEQ_PG_EN
      wait_nxt  = wait_cnt;
      fault_nxt = FAULT;
`endif
      case (state)
         S_OFF: begin
            if (en_eff) begin
               lvl_nxt   = LVL_ONE;
               cnt_nxt   = STEP;
               state_nxt = (NSEG == 1) ? S_ON : S_UP;
            end
         end
         S_UP: begin
            if (!en_eff) begin
               state_nxt = S_DN;
               cnt_nxt   = STEP;
`ifdef GF180MCU_FD_SC_MCU7T5V0__FILLSW_SEQ_PG_EN
            end else if (!pg_ok) begin
               // Delay is frozen until the newest segment reports good.
               wait_nxt = wait_cnt + (STEP_W + 1)'(1);
               if (wait_nxt == TMO_V) begin
                  fault_nxt = 1'b1;
                  state_nxt = S_DN;
                  cnt_nxt   = STEP;
               end
`endif
            end else if (cnt != '0) begin
               cnt_nxt = cnt - CNT_ONE;
            end else begin
               lvl_nxt = lvl + LVL_ONE;
               cnt_nxt = STEP;
               if (lvl_nxt == LVL_MAX) state_nxt = S_ON;
            end
         end
         S_ON: begin
            if (!en_eff) begin
               lvl_nxt   = lvl - LVL_ONE;
               cnt_nxt   = STEP;
               state_nxt = (lvl_nxt == LVL_ZERO) ? S_OFF : S_DN;
            end
         end
         S_DN: begin
            if (en_eff) begin
               // Reversal: keep lvl, restart a full interval upwards.
               state_nxt = S_UP;
               cnt_nxt   = STEP;
            end else if (cnt != '0) begin
               cnt_nxt = cnt - CNT_ONE;
            end else begin
               lvl_nxt = lvl - LVL_ONE;
               cnt_nxt = STEP;
               if (lvl_nxt == LVL_ZERO) state_nxt = S_OFF;
            end
         end
         default: state_nxt = S_OFF;
      endcase
`ifdef GF180MCU_FD_SC_MCU7T5V0__FILLSW_SEQ_PG_EN
      // The wait only measures time spent at one level while ramping up.
      if ((lvl_nxt != lvl) || (state_nxt != S_UP)) wait_nxt = '0;
`endif
   end

   // Outputs are registered from the next-state values so they change on
   // the same edge as the internal state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= S_OFF;
         lvl   <= '0;
         cnt   <= '0;
         SW    <= '0;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
      end else begin
         state <= state_nxt;
         lvl   <= lvl_nxt;
         cnt   <= cnt_nxt;
         SW    <= decode(lvl_nxt);
         BUSY  <= (state_nxt == S_UP) || (state_nxt == S_DN);
         DONE  <= (state_nxt == S_ON);
      end
   end

`ifdef GF180MCU_FD_SC_MCU7T5V0__FILLSW_SEQ_PG_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         wait_cnt <= '0;
         FAULT    <= 1'b0;
      end else begin
         wait_cnt <= wait_nxt;
         FAULT    <= fault_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__fillsw_seq.sv
// Testbench for gf180mcu_fd_sc_mcu7t5v0__fillsw_seq: per-cycle vector table
// on an NSEG=4 instance, plus directed sequences for NSEG=1 and power-good.
module tb_gf180mcu_fd_sc_mcu7t5v0__fillsw_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       en4, en1;
   logic [7:0] step;
   logic [3:0] sw4;
   logic       busy4, done4;
   logic [0:0] sw1;
   logic       busy1, done1;
`ifdef GF180MCU_FD_SC_MCU7T5V0__FILLSW_SEQ_PG_EN
   logic [3:0] pg4;
   logic [0:0] pg1;
   logic       fault4, fault1;
`endif

   always #5 clk = ~clk;

   gf180mcu_fd_sc_mcu7t5v0__fillsw_seq #(.NSEG(4), .STEP_W(8), .TMO(10)) u_dut4 (
      .CLK  (clk),
      .RST  (rst),
      .EN   (en4),
      .STEP (step),
      .SW   (sw4),
      .BUSY (busy4),
      .DONE (done4)
`ifdef GF180MCU_FD_SC_MCU7T5V0__FILLSW_SEQ_PG_EN
      ,
      .PG   (pg4),
      .FAULT(fault4)
`endif
   );

   gf180mcu_fd_sc_mcu7t5v0__fillsw_seq #(.NSEG(1), .STEP_W(8), .TMO(255)) u_dut1 (
      .CLK  (clk),
      .RST  (rst),
      .EN   (en1),
      .STEP (step),
      .SW   (sw1),
      .BUSY (busy1),
      .DONE (done1)
`ifdef GF180MCU_FD_SC_MCU7T5V0__FILLSW_SEQ_PG_EN
      ,
      .PG   (pg1),
      .FAULT(fault1)
`endif
   );

   typedef struct {
      logic       rst;
      logic       en;
      logic [7:0] step;
      logic [3:0] sw;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t vecs[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic add(input logic r, input logic e, input logic [7:0] s,
                      input logic [3:0] w, input logic b, input logic d);
      vec_t v;
      v.rst = r; v.en = e; v.step = s; v.sw = w; v.busy = b; v.done = d;
      vecs.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst  = 1'b1;
      en4  = 1'b0;
      en1  = 1'b0;
      step = 8'd0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__FILLSW_SEQ_PG_EN
      pg4  = 4'hF;
      pg1  = 1'b1;
`endif

      // Each row: inputs applied, one rising edge, then expected outputs.
      add(1, 0, 0, 4'b0000, 0, 0);   // reset
      add(1, 1, 0, 4'b0000, 0, 0);   // reset dominates EN
      // Ramp up, STEP=2; STEP changed mid-interval must not matter
      add(0, 1, 2, 4'b0001, 1, 0);   // edge 1
      add(0, 1, 9, 4'b0001, 1, 0);
      add(0, 1, 9, 4'b0001, 1, 0);
      add(0, 1, 2, 4'b0011, 1, 0);   // edge 4
      add(0, 1, 2, 4'b0011, 1, 0);
      add(0, 1, 2, 4'b0011, 1, 0);
      add(0, 1, 2, 4'b0111, 1, 0);   // edge 7
      add(0, 1, 2, 4'b0111, 1, 0);
      add(0, 1, 2, 4'b0111, 1, 0);
      add(0, 1, 2, 4'b1111, 0, 1);   // edge 10
      add(0, 1, 2, 4'b1111, 0, 1);
      // Ramp down, STEP=0
      add(0, 0, 0, 4'b0111, 1, 0);
      add(0, 0, 0, 4'b0011, 1, 0);
      add(0, 0, 0, 4'b0001, 1, 0);
      add(0, 0, 0, 4'b0000, 0, 0);
      add(0, 0, 0, 4'b0000, 0, 0);
      // Reversal, STEP=2
      add(0, 1, 2, 4'b0001, 1, 0);
      add(0, 1, 2, 4'b0001, 1, 0);
      add(0, 1, 2, 4'b0001, 1, 0);
      add(0, 1, 2, 4'b0011, 1, 0);
      add(0, 0, 2, 4'b0011, 1, 0);   // EN low sampled: lvl holds
      add(0, 0, 2, 4'b0011, 1, 0);
      add(0, 0, 2, 4'b0011, 1, 0);
      add(0, 0, 2, 4'b0001, 1, 0);   // 3 cycles after EN low
      add(0, 1, 2, 4'b0001, 1, 0);   // re-request
      add(0, 1, 2, 4'b0001, 1, 0);
      add(0, 1, 2, 4'b0001, 1, 0);
      add(0, 1, 2, 4'b0011, 1, 0);
      add(0, 1, 2, 4'b0011, 1, 0);
      add(0, 1, 2, 4'b0011, 1, 0);
      add(0, 1, 2, 4'b0111, 1, 0);
      add(0, 1, 2, 4'b0111, 1, 0);
      add(0, 1, 2, 4'b0111, 1, 0);
      add(0, 1, 2, 4'b1111, 0, 1);
      // Reset from ON, then reset mid-ramp at lvl=3
      add(1, 1, 0, 4'b0000, 0, 0);
      add(0, 1, 0, 4'b0001, 1, 0);
      add(0, 1, 0, 4'b0011, 1, 0);
      add(0, 1, 0, 4'b0111, 1, 0);
      add(1, 1, 0, 4'b0000, 0, 0);
      add(1, 1, 0, 4'b0000, 0, 0);
      add(0, 0, 0, 4'b0000, 0, 0);

      foreach (vecs[i]) begin
         rst  = vecs[i].rst;
         en4  = vecs[i].en;
         step = vecs[i].step;
         tick();
         check($sformatf("v%0d.sw", i),   32'(sw4),   32'(vecs[i].sw));
         check($sformatf("v%0d.busy", i), 32'(busy4), 32'(vecs[i].busy));
         check($sformatf("v%0d.done", i), 32'(done4), 32'(vecs[i].done));
      end

      // NSEG=1: straight to ON after one edge, BUSY never asserts.
      en4  = 1'b0;
      step = 8'd5;
      en1  = 1'b1;
      tick();
      check("n1.sw_on",   32'(sw1),   32'd1);
      check("n1.done_on", 32'(done1), 32'd1);
      check("n1.busy_on", 32'(busy1), 32'd0);
      for (int k = 0; k < 6; k++) begin
         tick();
         check($sformatf("n1.hold%0d.busy", k), 32'(busy1), 32'd0);
         check($sformatf("n1.hold%0d.sw", k),   32'(sw1),   32'd1);
      end
      en1 = 1'b0;
      tick();
      check("n1.sw_off",   32'(sw1),   32'd0);
      check("n1.done_off", 32'(done1), 32'd0);
      check("n1.busy_off", 32'(busy1), 32'd0);

`ifdef GF180MCU_FD_SC_MCU7T5V0__FILLSW_SEQ_PG_EN
      // PG held low: timeout after 10 waiting cycles, stepped ramp-down.
      rst = 1'b1;
      tick();
      check("pg.fault_rst", 32'(fault4), 32'd0);
      rst  = 1'b0;
      pg4  = 4'h0;
      step = 8'd0;
      en4  = 1'b1;
      tick();
      check("pg.sw_e1", 32'(sw4), 32'h1);
      for (int k = 2; k <= 10; k++) begin
         tick();
         check($sformatf("pg.wait_e%0d.fault", k), 32'(fault4), 32'd0);
         check($sformatf("pg.wait_e%0d.sw", k),   32'(sw4),    32'h1);
      end
      tick();
      check("pg.fault_e11", 32'(fault4), 32'd1);
      check("pg.busy_e11",  32'(busy4),  32'd1);
      check("pg.sw_e11",    32'(sw4),    32'h1);
      tick();
      check("pg.sw_e12",   32'(sw4),   32'h0);
      check("pg.busy_e12", 32'(busy4), 32'd0);
      pg4 = 4'hF;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("pg.masked%0d.sw", k),    32'(sw4),    32'h0);
         check($sformatf("pg.masked%0d.fault", k), 32'(fault4), 32'd1);
      end
      rst = 1'b1;
      en4 = 1'b0;
      tick();
      check("pg.fault_clr", 32'(fault4), 32'd0);
      rst = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__fillsw_seq.md
# gf180mcu_fd_sc_mcu7t5v0__fillsw_seq

Parametrised staged-enable sequencer for switchable fill/decap segments in the 7-track 5 V library. It is the active successor to the passive fill cells: instead of a fixed filler, it drives NSEG switch enables that bring capacitive fill segments onto the rail one at a time with a programmable inter-step delay, which limits inrush and di/dt. It sits next to a row of switched fill cells and is driven by the power-management logic.

## Interface
- NSEG, 8: number of switched segments (1..32).
- STEP_W, 8: width of the inter-step delay field.
- TMO, 255: power-good wait limit in cycles (used only with the PG feature; must fit in STEP_W+1 bits).

- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  level request: 1 = all segments on, 0 = all off.
- STEP  in  STEP_W  delay field; consecutive switch events are STEP+1 cycles apart.
- SW  out  NSEG  segment enables; SW[i] = (i < lvl).
- BUSY  out  1  ramp in progress (state UP or DN).
- DONE  out  1  all segments on (state ON).
- PG  in  NSEG  per-segment power-good (PG feature only).
- FAULT  out  1  sticky power-good timeout (PG feature only).

## Operation
- Internal state: lvl (0..NSEG), delay counter cnt (STEP_W bits), FSM {OFF, UP, ON, DN}. All outputs are registered.
- Reset: lvl=0, cnt=0, state OFF. SW=0, BUSY=0, DONE=0, FAULT=0.
- OFF, EN=1: lvl<=1 and cnt<=STEP. State becomes UP, or ON if NSEG=1.
- UP:
  - EN=0: state DN, cnt<=STEP, lvl unchanged.
  - Otherwise, cnt!=0: cnt decrements.
  - Otherwise, cnt=0: lvl increments and cnt<=STEP. When the new lvl equals NSEG, state becomes ON.
- ON, EN=0: lvl decrements and cnt<=STEP. State becomes DN, or OFF if the new lvl is 0.
- DN:
  - EN=1: state UP, cnt<=STEP, lvl unchanged. EN has priority.
  - Otherwise, cnt!=0: cnt decrements.
  - Otherwise, cnt=0: lvl decrements and cnt<=STEP. When the new lvl is 0, state becomes OFF.
- Turn-on order is SW[0] first. Turn-off order is the reverse, highest index first.
- STEP is sampled only when loaded into cnt. Changing STEP mid-interval does not affect the current interval.
- lvl never exceeds NSEG and never goes below 0. There is no wrap-around.

## Timing
- First switch event occurs 1 cycle after EN is sampled, in either direction.
- On a direction reversal, the next switch event occurs STEP+1 cycles after EN is sampled.
- Full ramp latency from EN sampled to DONE=1 is 1+(NSEG-1)(STEP+1) cycles.
- DONE rises on the same edge that sets SW[NSEG-1]. DONE falls on the same edge that clears it.
- BUSY and DONE are never both 1.
- RST has priority over all other inputs. RST mid-ramp clears SW to 0 on the next edge, with no sequenced ramp-down.

## Configuration
- Macro: GF180MCU_FD_SC_MCU7T5V0__FILLSW_SEQ_PG_EN.
- Defined: the PG and FAULT ports exist.
  - In UP, cnt does not start counting down until PG[lvl-1]=1.
  - A wait counter (cleared at each lvl change) counts the cycles spent waiting for PG.
  - If the wait reaches TMO cycles: FAULT<=1, state DN, normal stepped ramp-down.
  - While FAULT=1, EN is treated as 0. Only RST clears FAULT.
  - PG has no effect in DN, ON or OFF.
- Undefined: the PG and FAULT ports are absent, and sequencing is purely timer-based as above.

## Test plan
- Ramp up, NSEG=4, STEP=2: EN=1 sampled at edge 0 -> SW=0001@1, 0011@4, 0111@7, 1111@10. DONE=1@10. BUSY=1 over edges 1..9.
- Ramp down from ON, STEP=0: EN=0 sampled at edge 0 -> SW=0111@1, 0011@2, 0001@3, 0000@4. State OFF@4, BUSY=0@4.
- Reversal, NSEG=4, STEP=2: EN drops at the cycle after SW=0011 -> lvl holds. SW=0001 appears 3 cycles after EN is sampled low. EN re-asserted -> climbs again in STEP+1 spacing.
- Reset mid-ramp at lvl=3 -> SW=0, BUSY=0, DONE=0 on the next edge. Outputs hold at 0 while RST=1 regardless of EN.
- NSEG=1, STEP=5: EN=1 -> SW=1 and DONE=1 after 1 cycle, with BUSY never asserting.
- PG_EN, TMO=10: PG held 0 -> FAULT=1 after 10 waiting cycles, then stepped ramp-down to SW=0. EN=1 is ignored until RST.
